// File: rtl/board_state_engine.sv
// board_state_engine: 4x4 sliding-puzzle board register with player moves,
// LFSR-driven shuffle and solved detection, feeding the tile-number drawer.
//
// Parameters:
//   SHUFFLE_MOVES  legal random moves per shuffle (1..65535)
//   LFSR_SEED      non-zero reset value of the 16-bit shuffle LFSR
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_dir/cmd_ready  player move handshake (dir = blank motion:
//                                00 up, 01 down, 10 left, 11 right)
//   shuffle_start                one-cycle pulse, starts a shuffle
//   numbers                      packed board, cell k at [4k+3:4k], 0 = blank
//   blank_pos                    index of the blank cell
//   busy                         a move or shuffle is in progress
//   move_done/move_illegal       player move result pulses
//   board_changed                redraw hint pulse
//   solved                       board equals the solved pattern
//   move_count                   legal player moves since reset/shuffle
// Optional feature: define MOVE_COUNT_EN to build the move counter;
// otherwise move_count is tied to zero.
module board_state_engine #(
  parameter int unsigned SHUFFLE_MOVES = 200,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_dir,
  output logic        cmd_ready,
  input  logic        shuffle_start,
  output logic [63:0] numbers,
  output logic [3:0]  blank_pos,
  output logic        busy,
  output logic        move_done,
  output logic        move_illegal,
  output logic        board_changed,
  output logic        solved,
  output logic [15:0] move_count
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SHUFFLE
  } state_t;

  localparam logic [63:0] SOLVED =
    64'h0FED_CBA9_8765_4321;
  localparam logic [15:0] SHUF_N =
    16'(SHUFFLE_MOVES);

  state_t      state;
  state_t      state_n;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [1:0]  dir_q;
  logic [15:0] cnt;
  logic [63:0] board;
  logic [63:0] board_n;
  logic [3:0]  bp;
  logic [3:0]  nb;
  logic [3:0]  tile;
  logic [1:0]  dir;
  logic        legal;
  logic        act;
  logic        last;
  logic        accept;

  assign numbers   = board;
  assign blank_pos = bp;

  assign lfsr_fb = lfsr[15] ^ lfsr[13]
                 ^ lfsr[12] ^ lfsr[10];

  assign cmd_ready = (state == IDLE)
                   & ~shuffle_start;
  assign accept    = cmd_valid & cmd_ready;

  // Move decode: shuffle draws from the LFSR,
  // player moves use the latched direction.
  always_comb begin
    dir   = (state == SHUFFLE) ? lfsr[1:0]
                               : dir_q;
    legal = 1'b0;
    nb    = bp;
    unique case (dir)
      2'b00: begin
        legal = (bp[3:2] != 2'd0);
        nb    = bp - 4'd4;
      end
      2'b01: begin
        legal = (bp[3:2] != 2'd3);
        nb    = bp + 4'd4;
      end
      2'b10: begin
        legal = (bp[1:0] != 2'd0);
        nb    = bp - 4'd1;
      end
      2'b11: begin
        legal = (bp[1:0] != 2'd3);
        nb    = bp + 4'd1;
      end
      default: begin
        legal = 1'b0;
        nb    = bp;
      end
    endcase
    act  = legal & (state != IDLE);
    last = (state == SHUFFLE) & legal
         & (cnt == 16'd1);
    tile = board[{nb, 2'b00} +: 4];
    board_n = board;
    if (act) begin
      board_n[{bp, 2'b00} +: 4] = tile;
      board_n[{nb, 2'b00} +: 4] = 4'h0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (shuffle_start)
          state_n = SHUFFLE;
        else if (cmd_valid)
          state_n = APPLY;
      end
      APPLY:   state_n = IDLE;
      SHUFFLE: begin
        if (last)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      dir_q         <= 2'b00;
      cnt           <= 16'd0;
      board         <= SOLVED;
      bp            <= 4'd15;
      solved        <= 1'b1;
      busy          <= 1'b0;
      move_done     <= 1'b0;
      move_illegal  <= 1'b0;
      board_changed <= 1'b0;
    end else begin
      state  <= state_n;
      lfsr   <= {lfsr[14:0], lfsr_fb};
      board  <= board_n;
      solved <= (board_n == SOLVED);
      busy   <= (state_n != IDLE);
      if (act)
        bp <= nb;
      if (accept)
        dir_q <= cmd_dir;
      if (state == IDLE && shuffle_start)
        cnt <= SHUF_N;
      else if (state == SHUFFLE && legal)
        cnt <= cnt - 16'd1;
      move_done     <= (state == APPLY) & legal;
      move_illegal  <= (state == APPLY) & ~legal;
      // Shuffle only signals a redraw once,
      // after its final swap.
      board_changed <= ((state == APPLY) & legal)
                     | last;
    end
  end

`ifdef MOVE_COUNT_EN
  logic [15:0] mcnt;

  always_ff @(posedge clk) begin
    if (!resetn)
      mcnt <= 16'd0;
    else if (state == IDLE && shuffle_start)
      mcnt <= 16'd0;
    else if (state == APPLY && legal
             && mcnt != 16'hFFFF)
      mcnt <= mcnt + 16'd1;
  end

  assign move_count = mcnt;
`else
  assign move_count = 16'h0000;
`endif

endmodule

// File: tb/tb_board_state_engine.sv
// tb_board_state_engine: directed bench for board_state_engine with a
// cycle-level reference model of the puzzle rules and literal spot checks.
module tb_board_state_engine;

  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_dir = 2'b00;
  logic        shuffle_start = 1'b0;
  logic        cmd_ready;
  logic [63:0] numbers;
  logic [3:0]  blank_pos;
  logic        busy;
  logic        move_done;
  logic        move_illegal;
  logic        board_changed;
  logic        solved;
  logic [15:0] move_count;

  board_state_engine #(
    .SHUFFLE_MOVES(SM),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready),
    .shuffle_start(shuffle_start),
    .numbers(numbers),
    .blank_pos(blank_pos),
    .busy(busy),
    .move_done(move_done),
    .move_illegal(move_illegal),
    .board_changed(board_changed),
    .solved(solved),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference model: board as an integer array,
  // mode 0 idle, 1 applying a move, 2 shuffling.
  int m_board[16];
  int m_bp;
  int m_mode;
  int m_dir;
  int m_cnt;
  int m_count;
  int m_lfsr;
  bit m_done;
  bit m_ill;
  bit m_chg;
  bit go = 1'b0;

  function automatic void model_reset();
    for (int k = 0; k < 16; k++)
      m_board[k] = (k + 1) % 16;
    m_bp    = 15;
    m_mode  = 0;
    m_dir   = 0;
    m_cnt   = 0;
    m_count = 0;
    m_lfsr  = 16'hACE1;
    m_done  = 1'b0;
    m_ill   = 1'b0;
    m_chg   = 1'b0;
  endfunction

  function automatic bit try_move(int d);
    int r;
    int c;
    int t;
    bit ok;
    r  = m_bp / 4;
    c  = m_bp % 4;
    ok = 1'b0;
    t  = m_bp;
    case (d)
      0: begin ok = (r > 0); t = m_bp - 4; end
      1: begin ok = (r < 3); t = m_bp + 4; end
      2: begin ok = (c > 0); t = m_bp - 1; end
      default: begin
        ok = (c < 3); t = m_bp + 1;
      end
    endcase
    if (ok) begin
      m_board[m_bp] = m_board[t];
      m_board[t]    = 0;
      m_bp          = t;
    end
    return ok;
  endfunction

  function automatic bit m_is_solved();
    for (int k = 0; k < 16; k++)
      if (m_board[k] != (k + 1) % 16)
        return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      m_ill  = 1'b0;
      m_chg  = 1'b0;
      case (m_mode)
        0: begin
          if (shuffle_start) begin
            m_mode  = 2;
            m_cnt   = SM;
            m_count = 0;
          end else if (cmd_valid) begin
            m_mode = 1;
            m_dir  = int'(cmd_dir);
          end
        end
        1: begin
          if (try_move(m_dir)) begin
            m_done = 1'b1;
            m_chg  = 1'b1;
            if (m_count < 65535)
              m_count++;
          end else begin
            m_ill = 1'b1;
          end
          m_mode = 0;
        end
        default: begin
          if (try_move(m_lfsr % 4)) begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_mode = 0;
              m_chg  = 1'b1;
            end
          end
        end
      endcase
      m_lfsr = ((m_lfsr << 1)
             | (((m_lfsr >> 15) ^ (m_lfsr >> 13)
             ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1))
             & 16'hFFFF;
    end
    go = 1'b1;
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    logic [63:0] en;
    int          mc;
    if (go) begin
      #2;
      en = '0;
      for (int k = 0; k < 16; k++)
        en[4*k +: 4] = 4'(m_board[k]);
`ifdef MOVE_COUNT_EN
      mc = m_count;
`else
      mc = 0;
`endif
      check("numbers", numbers, en);
      check("blank_pos", 64'(blank_pos),
            64'(m_bp));
      check("busy", 64'(busy),
            64'(m_mode != 0));
      check("move_done", 64'(move_done),
            64'(m_done));
      check("move_illegal", 64'(move_illegal),
            64'(m_ill));
      check("board_changed", 64'(board_changed),
            64'(m_chg));
      check("solved", 64'(solved),
            64'(m_is_solved()));
      check("move_count", 64'(move_count),
            64'(mc));
      check("cmd_ready", 64'(cmd_ready),
            64'(m_mode == 0 && !shuffle_start));
    end
  end

  task automatic do_move(input logic [1:0] d,
                         output bit done,
                         output bit ill);
    done = 1'b0;
    ill  = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #3;
      if (move_done)
        done = 1'b1;
      if (move_illegal)
        ill = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  localparam logic [63:0] SOLVED_L =
    64'h0FED_CBA9_8765_4321;

  initial begin
    bit          d;
    bit          il;
    bit          fin;
    int          nchg;
    int          ndone;
    int          cyc;
    logic [15:0] mask;
    logic [63:0] sh;
    logic [15:0] exp_mc;

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #3;
    check("t1_numbers", numbers, SOLVED_L);
    check("t1_blank", 64'(blank_pos), 64'd15);
    check("t1_solved", 64'(solved), 64'd1);
    check("t1_ready", 64'(cmd_ready), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    do_move(2'b00, d, il);
    check("t2_up_numbers", numbers,
          64'hCFED_0BA9_8765_4321);
    check("t2_up_blank", 64'(blank_pos), 64'd11);
    check("t2_up_solved", 64'(solved), 64'd0);
    check("t2_up_done", 64'(d), 64'd1);
    do_move(2'b01, d, il);
    check("t2_dn_numbers", numbers, SOLVED_L);
    check("t2_dn_solved", 64'(solved), 64'd1);
    check("t2_dn_done", 64'(d), 64'd1);

    do_move(2'b01, d, il);
    check("t3_dn_ill", 64'(il), 64'd1);
    check("t3_dn_done", 64'(d), 64'd0);
    check("t3_dn_numbers", numbers, SOLVED_L);
    do_move(2'b11, d, il);
    check("t3_rt_ill", 64'(il), 64'd1);
    check("t3_rt_done", 64'(d), 64'd0);
    check("t3_rt_numbers", numbers, SOLVED_L);

    pulse_reset();
    do_move(2'b11, d, il);
    do_move(2'b00, d, il);
    do_move(2'b00, d, il);
    do_move(2'b10, d, il);
`ifdef MOVE_COUNT_EN
    exp_mc = 16'd3;
`else
    exp_mc = 16'd0;
`endif
    check("t6_count", 64'(move_count),
          64'(exp_mc));
    check("t6_blank", 64'(blank_pos), 64'd6);

    @(negedge clk);
    shuffle_start = 1'b1;
    cmd_valid     = 1'b1;
    cmd_dir       = 2'b00;
    @(negedge clk);
    shuffle_start = 1'b0;
    cmd_valid     = 1'b0;
    nchg  = 0;
    ndone = 0;
    fin   = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 400; i++) begin
      #3;
      if (board_changed)
        nchg++;
      if (move_done)
        ndone++;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    check("t4_finished", 64'(fin), 64'd1);
    check("t4_min_cycles", 64'(cyc >= SM), 64'd1);
    check("t4_changed_once", 64'(nchg), 64'd1);
    check("t4_no_cmd", 64'(ndone), 64'd0);
    mask = '0;
    for (int k = 0; k < 16; k++)
      mask[numbers[4*k +: 4]] = 1'b1;
    check("t4_perm", 64'(mask), 64'hFFFF);
    sh = numbers >> (4 * blank_pos);
    check("t4_blank_zero", 64'(sh[3:0]), 64'd0);
    check("t6_shuf_clear", 64'(move_count),
          64'd0);

    @(negedge clk);
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("t5_busy_pre", 64'(busy), 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #3;
    check("t5_numbers", numbers, SOLVED_L);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_blank", 64'(blank_pos), 64'd15);
    check("t5_ready", 64'(cmd_ready), 64'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #4;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
